// File: rtl/dcd_pkg.sv
// dcd_pkg: slot value encodings, FSM state type and default sizes shared by the decision writer
package dcd_pkg;
  localparam int DEF_NUM_VARS = 8;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_IDX_W = 3;
  localparam int DEF_LVL_W = 4;
  localparam logic [1:0] VAL_FREE = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE = 2'b10;
  localparam logic [1:0] VAL_CONF = 2'b11;
  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_e;
  function automatic logic [2:0] dcd_slot(input logic pol);
    return {pol ? VAL_TRUE : VAL_FALSE, 1'b0};
  endfunction
endpackage

// File: rtl/dcd_scan_ctr.sv
// dcd_scan_ctr: saturating read-address issuer with 1-deep returned-address/valid pipe and last-index flag (clk, rst active-low async, clr_i, adv_i -> addr_o, ret_addr_o, ret_vld_o, ret_last_o)
module dcd_scan_ctr #(
  parameter int NUM_VARS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] addr_o,
  output logic [IDX_W-1:0] ret_addr_o,
  output logic             ret_vld_o,
  output logic             ret_last_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VARS - 1);
  logic [IDX_W-1:0] addr_q, addr_d, ret_q, ret_d;
  logic vld_q, vld_d;
  always_comb begin
    addr_d = clr_i ? '0 : adv_i ? (addr_q == LAST ? LAST : addr_q + IDX_W'(1)) : addr_q;
    ret_d = adv_i ? addr_q : ret_q;
    vld_d = adv_i & ~clr_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      ret_q <= '0;
      vld_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ret_q <= ret_d;
      vld_q <= vld_d;
    end
  end
  assign addr_o = addr_q;
  assign ret_addr_o = ret_q;
  assign ret_vld_o = vld_q;
  assign ret_last_o = ret_q == LAST;
endmodule

// File: rtl/dcd_assign_var.sv
// dcd_assign_var: finds the lowest free variable in the state list and writes a leveled decision for it (clk, rst active-low async, start_i/kill_i/cur_lvl_i, rd_addr_o/var_value_i read port, wr_* write port, busy_o/done_o/found_o/dcd_index_o status; optional DCD_PHASE_SAVE_EN saved-phase polarity)
module dcd_assign_var
  import dcd_pkg::*;
#(
  parameter int NUM_VARS = DEF_NUM_VARS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int LVL_W = DEF_LVL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [LVL_W-1:0] cur_lvl_i,
  output logic [IDX_W-1:0] rd_addr_o,
  input  logic [WIDTH-1:0] var_value_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0] wr_value_o,
  output logic [LVL_W-1:0] wr_lvl_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [IDX_W-1:0] dcd_index_o
);
  state_e state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [IDX_W-1:0] idx_q, idx_d, ret_addr;
  logic found_q, found_d, ret_vld, ret_last, accept, checked, is_free, hit, miss_end, pol;
  logic unused_implied;
  assign unused_implied = var_value_i[0];
  assign accept = state_q == IDLE && start_i && !kill_i;
  assign checked = state_q == SCAN && ret_vld;
  assign is_free = var_value_i[2:1] == VAL_FREE;
  assign hit = checked && is_free;
  assign miss_end = checked && !is_free && ret_last;
  dcd_scan_ctr #(.NUM_VARS(NUM_VARS), .IDX_W(IDX_W)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .adv_i     (state_q == SCAN),
    .addr_o    (rd_addr_o),
    .ret_addr_o(ret_addr),
    .ret_vld_o (ret_vld),
    .ret_last_o(ret_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lvl_q <= '0;
      idx_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      idx_q <= idx_d;
      found_q <= found_d;
    end
  end
  always_comb begin
    state_d = kill_i ? IDLE
            : state_q == IDLE ? (start_i ? SCAN : IDLE)
            : state_q == SCAN ? (hit ? WRITE : miss_end ? DONE : SCAN)
            : state_q == WRITE ? DONE : IDLE;
    lvl_d = accept ? cur_lvl_i : lvl_q;
    idx_d = accept ? '0 : (hit && !kill_i) ? ret_addr : idx_q;
    found_d = accept ? 1'b0 : (state_q == WRITE && !kill_i) ? 1'b1 : found_q;
  end
  always_comb begin
    wr_en_o = state_q == WRITE && !kill_i;
    wr_addr_o = wr_en_o ? idx_q : '0;
    wr_value_o = wr_en_o ? WIDTH'(dcd_slot(pol)) : '0;
    wr_lvl_o = wr_en_o ? lvl_q : '0;
    busy_o = state_q != IDLE;
    done_o = state_q == DONE && !kill_i;
    found_o = found_q;
    dcd_index_o = idx_q;
  end
`ifdef DCD_PHASE_SAVE_EN
  logic [NUM_VARS-1:0] phase_q, phase_d;
  always_comb begin
    phase_d = phase_q;
    if (checked && !is_free && var_value_i[2:1] != VAL_CONF) phase_d[ret_addr] = var_value_i[2];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= '0;
    else phase_q <= phase_d;
  end
  assign pol = phase_q[idx_q];
`else
  assign pol = 1'b0;
`endif
endmodule

// File: tb/tb_dcd_assign_var.sv
// tb_dcd_assign_var: randomized self-checking bench for dcd_assign_var against a slot-list reference model
module tb_dcd_assign_var;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b0, start_i = 1'b0, kill_i = 1'b0;
  logic [3:0] cur_lvl_i = '0;
  logic [2:0] rd_addr_o, wr_addr_o, dcd_index_o;
  logic [2:0] var_value_i = '0, wr_value_o;
  logic [3:0] wr_lvl_o;
  logic wr_en_o, busy_o, done_o, found_o;
  logic [2:0] mem [N];
  logic [N-1:0] mdl_phase = '0;
  int checks = 0, errors = 0;

  dcd_assign_var dut (
    .clk(clk), .rst(rst), .start_i(start_i), .kill_i(kill_i), .cur_lvl_i(cur_lvl_i),
    .rd_addr_o(rd_addr_o), .var_value_i(var_value_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_value_o(wr_value_o), .wr_lvl_o(wr_lvl_o), .busy_o(busy_o), .done_o(done_o),
    .found_o(found_o), .dcd_index_o(dcd_index_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) var_value_i <= mem[rd_addr_o];

  function automatic logic [2:0] nonfree();
    logic [1:0] v;
    v = 2'($urandom_range(1, 3));
    return {v, 1'($urandom_range(0, 1))};
  endfunction

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (mem[i][2:1] == 2'b00) return i;
    return -1;
  endfunction

  task automatic learn_phase(input int upto);
    for (int i = 0; i < upto; i++)
      if (mem[i][2:1] == 2'b01 || mem[i][2:1] == 2'b10) mdl_phase[i] = mem[i][2];
  endtask

  task automatic fill(input int free_pct);
    for (int i = 0; i < N; i++) mem[i] = ($urandom_range(0, 99) < free_pct) ? {2'b00, 1'($urandom_range(0, 1))} : nonfree();
  endtask

  task automatic do_decision(input logic [3:0] lvl, input bit hammer, input string name);
    int k, exp_done, wr_cnt, done_cnt, wr_cyc, done_cyc;
    logic exp_pol, fnd;
    logic [2:0] wa, wv, idx, exp_wv;
    logic [3:0] wl;
    k = first_free();
    exp_done = k >= 0 ? k + 4 : N + 2;
    learn_phase(k >= 0 ? k : N);
`ifdef DCD_PHASE_SAVE_EN
    exp_pol = k >= 0 ? mdl_phase[k] : 1'b0;
`else
    exp_pol = 1'b0;
`endif
    exp_wv = exp_pol ? 3'b100 : 3'b010;
    wr_cnt = 0; done_cnt = 0; wr_cyc = -1; done_cyc = -1;
    fnd = 1'b0; idx = '0; wa = '0; wv = '0; wl = '0;
    @(negedge clk);
    start_i = 1'b1;
    cur_lvl_i = lvl;
    @(posedge clk);
    #1 start_i = 1'b0;
    cur_lvl_i = 4'($urandom);
    for (int c = 1; c <= N + 6; c++) begin
      @(negedge clk);
      if (wr_en_o) begin
        wr_cnt++; wr_cyc = c; wa = wr_addr_o; wv = wr_value_o; wl = wr_lvl_o;
      end
      if (done_o) begin
        done_cnt++; done_cyc = c; fnd = found_o; idx = dcd_index_o;
      end
      start_i = hammer && c <= exp_done;
    end
    start_i = 1'b0;
    if (wr_cnt > 0) mem[wa] = wv;
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_done) begin
      errors++; $display("FAIL %s done count %0d cycle %0d, want 1 at %0d", name, done_cnt, done_cyc, exp_done);
    end
    checks++;
    if (fnd !== (k >= 0) || idx !== 3'(k >= 0 ? k : 0)) begin
      errors++; $display("FAIL %s found/index got %b/%0d want %b/%0d", name, fnd, idx, k >= 0, k >= 0 ? k : 0);
    end
    checks++;
    if (found_o !== (k >= 0) || dcd_index_o !== 3'(k >= 0 ? k : 0)) begin
      errors++; $display("FAIL %s held found/index got %b/%0d", name, found_o, dcd_index_o);
    end
    checks++;
    if (k < 0) begin
      if (wr_cnt !== 0) begin
        errors++; $display("FAIL %s write count got %0d want 0", name, wr_cnt);
      end
    end else if (wr_cnt !== 1 || wr_cyc !== k + 3 || wa !== 3'(k) || wv !== exp_wv || wl !== lvl) begin
      errors++;
      $display("FAIL %s write n=%0d cyc=%0d addr=%0d val=%b lvl=%0d want n=1 cyc=%0d addr=%0d val=%b lvl=%0d",
               name, wr_cnt, wr_cyc, wa, wv, wl, k + 3, k, exp_wv, lvl);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_addr_o, wr_en_o, wr_addr_o, wr_value_o, wr_lvl_o, done_o, found_o, dcd_index_o} !== '0) begin
      errors++; $display("FAIL reset outputs nonzero rd=%0d we=%b done=%b found=%b idx=%0d", rd_addr_o, wr_en_o, done_o, found_o, dcd_index_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset busy got %b want 0", busy_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b we=%b want 0", busy_o, wr_en_o);
    end
  endtask

  task automatic test_basic();
    fill(20);
    mem[0] = 3'b010; mem[1] = 3'b100; mem[2] = 3'b000;
    do_decision(4'd3, 1'b0, "basic");
  endtask

  task automatic test_no_free();
    fill(0);
    do_decision(4'($urandom), 1'b0, "no_free");
  endtask

  task automatic test_back_to_back();
    fill(30);
    mem[0] = 3'b001;
    do_decision(4'($urandom), 1'b1, "slot0_busy_start");
  endtask

  task automatic test_kill();
    int k, wr_cnt, done_cnt;
    fill(0);
    k = 4;
    mem[k] = 3'b000;
    wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start_i = 1'b1;
    cur_lvl_i = 4'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= N + 6; c++) begin
      @(negedge clk);
      if (c == k + 3) begin
        checks++;
        if (busy_o !== 1'b0) begin
          errors++; $display("FAIL kill busy after kill got %b want 0", busy_o);
        end
      end
      if (wr_en_o) wr_cnt++;
      if (done_o) done_cnt++;
      kill_i = c == k + 2;
    end
    kill_i = 1'b0;
    learn_phase(k);
    checks++;
    if (wr_cnt !== 0 || done_cnt !== 0) begin
      errors++; $display("FAIL kill writes=%0d dones=%0d want 0/0", wr_cnt, done_cnt);
    end
    checks++;
    if (found_o !== 1'b0) begin
      errors++; $display("FAIL kill found got %b want 0", found_o);
    end
    do_decision(4'd5, 1'b0, "post_kill");
  endtask

  task automatic test_async_reset();
    fill(0);
    mem[N-1] = 3'b000;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || rd_addr_o !== 3'd2) begin
      errors++; $display("FAIL async_pre busy=%b rd=%0d want 1/2", busy_o, rd_addr_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, rd_addr_o, wr_en_o, done_o, found_o, dcd_index_o, wr_value_o} !== '0) begin
      errors++; $display("FAIL async_reset busy=%b rd=%0d we=%b done=%b want all 0", busy_o, rd_addr_o, wr_en_o, done_o);
    end
    mdl_phase = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (N + 4) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL async_idle busy=%b done=%b want 0/0", busy_o, done_o);
    end
  endtask

  task automatic test_phase();
    for (int i = 0; i < N; i++) mem[i] = 3'b010;
    mem[3] = 3'b100;
    mem[5] = 3'b000;
    do_decision(4'd7, 1'b0, "phase_first");
    mem[3] = 3'b000;
    do_decision(4'd8, 1'b0, "phase_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      fill(i % 5 == 0 ? 0 : 15);
      do_decision(4'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 3'b010;
    test_reset();
    test_basic();
    test_no_free();
    test_back_to_back();
    test_kill();
    test_async_reset();
    test_phase();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcd_assign_var.md
Name: dcd_assign_var

Overview:
- Decision writer for the SAT engine state list; counterpart to the per-variable free-detect decode logic.
- On start, scans the variable state list sequentially and finds the lowest-index free variable.
- Writes a decision assignment for that variable back into the state list, tagged with the current decision level.
- Reports completion with found/not-found and the chosen index to the core controller.

Parameters:
NUM_VARS, 8, number of variable slots in the state list (>=2)
WIDTH, 3, bits per variable slot: [2:1] value, [0] implied flag
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_VARS
LVL_W, 4, decision level width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start_i  input  1  request one decision; sampled only in IDLE
kill_i  input  1  synchronous abort; highest priority after reset
cur_lvl_i  input  LVL_W  level stamped on the write; sampled with start_i
rd_addr_o  output  IDX_W  state-list read address
var_value_i  input  WIDTH  read data, valid exactly 1 cycle after rd_addr_o
wr_en_o  output  1  one-cycle write strobe
wr_addr_o  output  IDX_W  write address
wr_value_o  output  WIDTH  written slot value
wr_lvl_o  output  LVL_W  written decision level
busy_o  output  1  high in any state except IDLE
done_o  output  1  one-cycle completion pulse
found_o  output  1  valid with done_o: 1 = free variable assigned
dcd_index_o  output  IDX_W  chosen index; held until the next start

Behaviour:
- Slot encoding: value 00 = free, 01 = false, 10 = true, 11 = conflict. Only 00 counts as free.
- Reset (rst low, asynchronous): state IDLE. All outputs are 0: rd_addr_o, wr_*, busy_o, done_o, found_o, dcd_index_o, and the level register.
- States: IDLE, SCAN, WRITE, DONE.
- IDLE: when start_i=1, capture cur_lvl_i and clear the scan counter, then go to SCAN.
- SCAN: rd_addr_o = issue counter. It starts at 0 in the first SCAN cycle and increments each cycle, saturating at NUM_VARS-1.
- Each cycle, var_value_i is checked against the address issued in the previous cycle (tracked by a 1-deep valid/addr pipe).
- Timing: start is sampled at edge E0. Address a is driven during cycle a+1, and its data is present during cycle a+2.
- First free hit at index k: at the end of cycle k+2, latch dcd_index_o=k and go to WRITE. The read already issued for k+1 is discarded.
- No free slot: after the data for index NUM_VARS-1 is checked, go to DONE with found=0. dcd_index_o is then 0. No write occurs.
- WRITE (one cycle, cycle k+3):
  - wr_en_o=1, wr_addr_o=k
  - wr_value_o = {polarity, 0}: 010 for false, 100 for true; implied bit 0
  - wr_lvl_o = captured level
  - then go to DONE
- DONE (one cycle): done_o=1, found_o valid, then return to IDLE. found_o holds until the next start.
- start_i while busy is ignored. start_i and done_o in the same cycle: start is ignored (state is not IDLE).
- kill_i=1 in any state: next state IDLE, no write and no done pulse. wr_en_o is forced 0 in the kill cycle.
- Idle defaults: wr_en_o=0 and done_o=0. rd_addr_o holds its last value when idle.
- Best-case latency (k=0): done_o in cycle 4. Worst case: NUM_VARS+2 cycles to done without a write.

Optional Feature:
- Macro: DCD_PHASE_SAVE_EN
- Defined:
  - Keep a NUM_VARS-bit saved_phase register, reset to 0.
  - During SCAN, each checked slot with value 01 or 10 updates saved_phase[idx] <= value[2]; value 11 does not update.
  - Chosen polarity = saved_phase[k]: 1 writes 100, 0 writes 010.
  - kill_i does not clear saved_phase.
- Undefined: polarity is always false (wr_value_o=010) and there is no phase storage.

Decomposition:
- Shared package dcd_pkg:
  - slot value constants VAL_FREE=2'b00, VAL_FALSE=2'b01, VAL_TRUE=2'b10, VAL_CONF=2'b11
  - state enum {IDLE, SCAN, WRITE, DONE}
  - default WIDTH/LVL_W constants
- One natural sub-module: dcd_scan_ctr. It holds the issue counter, the 1-deep returned-address/valid pipe and the last-index flag. It keeps the FSM free of address arithmetic.

Test Plan:
- NUM_VARS=8, slots [01,10,00,...], start, cur_lvl=3 -> wr_en cycle 5, wr_addr=2, wr_value=010, wr_lvl=3; done cycle 6, found=1, dcd_index=2.
- All slots 01/10/11 -> no wr_en; done cycle 10 (NUM_VARS+2), found=0, dcd_index=0.
- Slot 0 free -> wr_en cycle 3, done cycle 4. A second start pulsed during busy is ignored: exactly one done.
- kill_i asserted in the cycle SCAN sees the hit -> no wr_en, no done, busy_o=0 next cycle. A new start then completes normally.
- rst low mid-SCAN (asynchronous, between edges) -> all outputs 0 immediately, state IDLE.
- DCD_PHASE_SAVE_EN: first scan sees slot 3 = 10, slot 5 free -> writes slot 5 = 010. Then slot 3 is cleared to 00 and a second start -> writes slot 3 = 100.
